// File: rtl/i2s_sample_feeder.sv
// i2s_sample_feeder: sample FIFO plus prefill/run/underrun sequencer feeding
// the i2s transmitter one sample per rising edge of its ready signal.
module i2s_sample_feeder #(
  parameter int BPS         = 24,
  parameter int DEPTH       = 16,
  parameter int START_LEVEL = 8,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_start,
  input  logic              in_flush,
  input  logic [BPS-1:0]    in_wr_data,
  input  logic              in_wr_valid,
  output logic              out_wr_ready,
  input  logic              in_i2s_ready,
  output logic [BPS-1:0]    out_sample,
  output logic              out_en,
  output logic [ADDR_W:0]   out_level,
  output logic              out_underrun,
  output logic [15:0]       out_underrun_cnt
);

  localparam logic [ADDR_W:0] FULL_LV  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] START_LV = (ADDR_W+1)'(START_LEVEL);
  localparam logic [ADDR_W:0] ONE_LV   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_P  = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PRIME, S_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic [BPS-1:0]      r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]     r_level;
  logic [BPS-1:0]      r_sample;
  logic                r_en;
  logic                r_ready_d;
  logic                r_underrun;
  logic [15:0]         r_cnt;

  logic w_rdy_rise, w_wr, w_pop, w_urun, w_en_nxt, w_flush;

  // Edge detect is gated by out_en so the idle-high ready never looks like a request.
  assign w_rdy_rise   = in_i2s_ready & ~r_ready_d & r_en;
  assign out_wr_ready = (r_level != FULL_LV);
  assign w_wr         = in_wr_valid & out_wr_ready & ~w_flush;

  assign out_sample       = r_sample;
  assign out_en           = r_en;
  assign out_level        = r_level;
  assign out_underrun     = r_underrun;
  assign out_underrun_cnt = r_cnt;

  // State register.
  always_ff @(posedge in_clk) begin
    if (in_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, pop/underrun strobes and next out_en.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_urun      = 1'b0;
    w_en_nxt    = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_flush = in_flush;
        if (in_start) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        if (!in_start)               w_state_nxt = S_IDLE;
        else if (r_level >= START_LV) w_state_nxt = S_PRIME;
      end
      S_PRIME: begin
        // out_en stays low this cycle so the sample settles before in_en rises.
        w_pop       = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_en_nxt = 1'b1;
        if (w_rdy_rise) begin
          if (r_level != '0) begin
            w_pop = 1'b1;
          end else begin
            w_urun      = 1'b1;
            w_en_nxt    = 1'b0;
            w_state_nxt = S_FILL;
          end
        end
        if (!in_start) begin
          w_en_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage; no reset needed, pointers qualify contents.
  always_ff @(posedge in_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= in_wr_data;
  end

  // Pointers, level, output sample/enable, ready delay and underrun tracking.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_sample   <= '0;
      r_en       <= 1'b0;
      r_ready_d  <= 1'b1;
      r_underrun <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_ready_d <= in_i2s_ready;
      r_en      <= w_en_nxt;
      if (w_flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_level    <= '0;
        r_underrun <= 1'b0;
        r_cnt      <= '0;
      end else begin
        if (w_wr)  r_wr_ptr <= r_wr_ptr + ONE_P;
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + ONE_P;
          r_sample <= r_mem[r_rd_ptr];
        end
        case ({w_wr, w_pop})
          2'b10:   r_level <= r_level + ONE_LV;
          2'b01:   r_level <= r_level - ONE_LV;
          default: r_level <= r_level;
        endcase
        if (w_urun) begin
          r_underrun <= 1'b1;
          if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

endmodule
